// File: rtl/tpu_top_if.sv
// Bus bundle for tpu_top: job control, external SRAM port, weight FIFO port
// and activation-pipeline strobes. Clock and reset stay plain ports on the top.
//   master : drives start, SRAM/FIFO writes, we_rl, valid_address, addr_ctrl_en
//   slave  : drives end_, sram_data_out, fifo_data_out, fifo_empty, fifo_full
interface tpu_top_if #(
    parameter int unsigned ADDRESSSIZE = 10,
    parameter int unsigned WORDSIZE    = 64,
    parameter int unsigned WEIGHT_BW   = 8,
    parameter int unsigned NUM_PE_ROWS = 8,
    parameter int unsigned MATRIX_SIZE = 8
);
    localparam int unsigned TileW = WEIGHT_BW * NUM_PE_ROWS * MATRIX_SIZE;

    logic                   start;
    logic                   end_;
    logic                   sram_write_enable;
    logic [ADDRESSSIZE-1:0] sram_address;
    logic [WORDSIZE-1:0]    sram_data_in;
    logic [WORDSIZE-1:0]    sram_data_out;
    logic                   fifo_write_enable;
    logic                   fifo_read_enable;
    logic [TileW-1:0]       fifo_data_in;
    logic [TileW-1:0]       fifo_data_out;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   we_rl;
    logic                   valid_address;
    logic                   addr_ctrl_en;

    modport master (
        output start, sram_write_enable, sram_address, sram_data_in,
               fifo_write_enable, fifo_read_enable, fifo_data_in,
               we_rl, valid_address, addr_ctrl_en,
        input  end_, sram_data_out, fifo_data_out, fifo_empty, fifo_full
    );

    modport slave (
        input  start, sram_write_enable, sram_address, sram_data_in,
               fifo_write_enable, fifo_read_enable, fifo_data_in,
               we_rl, valid_address, addr_ctrl_en,
        output end_, sram_data_out, fifo_data_out, fifo_empty, fifo_full
    );
endinterface

// File: rtl/tpu_top.sv
// 8x8 weight-stationary matrix-vector accelerator.
// Activation vectors are read from a single-port SRAM, multiplied by a weight
// tile loaded through a small FIFO, saturated to WEIGHT_BW, collected in a
// result buffer and flushed back to SRAM at RESULT_BASE by the address
// controller, which then raises end_.
// Ports:
//   clk  : clock, all state on the rising edge
//   rstn : synchronous reset, active HIGH despite the name
//   bus  : tpu_top_if.slave (job control, SRAM port, FIFO port, strobes)
module tpu_top #(
    parameter int unsigned ADDRESSSIZE = 10,
    parameter int unsigned WORDSIZE    = 64,
    parameter int unsigned WEIGHT_BW   = 8,
    parameter int unsigned NUM_PE_ROWS = 8,
    parameter int unsigned MATRIX_SIZE = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned RESULT_BASE = 512
) (
    input logic      clk,
    input logic      rstn,
    tpu_top_if.slave bus
);
    localparam int unsigned TileW = WEIGHT_BW * NUM_PE_ROWS * MATRIX_SIZE;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ResW  = $clog2(MATRIX_SIZE + 1);
    localparam int unsigned SelW  = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int unsigned AccW  = 2 * WEIGHT_BW + $clog2(MATRIX_SIZE) + 1;

    localparam logic signed [AccW-1:0] SatMax =
        {{(AccW - WEIGHT_BW + 1){1'b0}}, {(WEIGHT_BW - 1){1'b1}}};
    localparam logic signed [AccW-1:0] SatMin =
        {{(AccW - WEIGHT_BW + 1){1'b1}}, {(WEIGHT_BW - 1){1'b0}}};

    // ------------------------------------------------------------------ SRAM
    logic [WORDSIZE-1:0]    r_mem [2**ADDRESSSIZE];
    logic [WORDSIZE-1:0]    r_sram_q;

    // ------------------------------------------------------------------ FIFO
    logic [TileW-1:0]       r_fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]        r_wr_ptr;
    logic [PtrW-1:0]        r_rd_ptr;
    logic [CntW-1:0]        r_fifo_cnt;
    logic [TileW-1:0]       r_fifo_dout;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_push;
    logic                   w_pop;

    // ------------------------------------------------------- weights and MAC
    logic signed [WEIGHT_BW-1:0] r_w [NUM_PE_ROWS][MATRIX_SIZE];
    logic signed [AccW-1:0]      w_acc [NUM_PE_ROWS];
    logic [WORDSIZE-1:0]         w_result;

    // ---------------------------------------- result buffer and flush control
    logic                   r_act_valid;
    logic [ResW-1:0]        r_res_count;
    logic [WORDSIZE-1:0]    r_buf [MATRIX_SIZE];
    logic [ResW-1:0]        r_flush_idx;
    logic                   r_end;
    logic                   w_capture;
    logic [SelW-1:0]        w_cap_sel;
    logic                   w_flush_wr;
    logic [SelW-1:0]        w_flush_sel;
    logic [ADDRESSSIZE-1:0] w_flush_addr;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // ---------------------------------------------------------- SRAM array
    // start wins over a pending flush write so a restarted job never writes
    // stale buffer entries.
    assign w_flush_wr   = bus.addr_ctrl_en && (r_res_count != '0) && !r_end && !bus.start;
    assign w_flush_sel  = r_flush_idx[SelW-1:0];
    assign w_flush_addr = ADDRESSSIZE'(RESULT_BASE) + ADDRESSSIZE'(r_flush_idx);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            if (bus.addr_ctrl_en) begin
                if (w_flush_wr) begin
                    r_mem[w_flush_addr] <= r_buf[w_flush_sel];
                end
            end else if (bus.sram_write_enable) begin
                r_mem[bus.sram_address] <= bus.sram_data_in;
            end
        end
    end

    // Read-before-write: a same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_sram_q <= '0;
        end else if (!bus.addr_ctrl_en) begin
            r_sram_q <= r_mem[bus.sram_address];
        end
    end

    // ---------------------------------------------------------- weight FIFO
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_fifo_full  = (r_fifo_cnt == CntW'(FIFO_DEPTH));
    // A push while full is dropped even if a pop frees a slot this cycle.
    assign w_push       = bus.fifo_write_enable && !w_fifo_full;
    assign w_pop        = bus.fifo_read_enable && !w_fifo_empty;

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            r_fifo_dout <= '0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= bus.fifo_data_in;
                r_wr_ptr             <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_fifo_dout <= r_fifo_mem[r_rd_ptr];
                r_rd_ptr    <= ptr_inc(r_rd_ptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CntW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CntW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------ weight registers
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int r = 0; r < NUM_PE_ROWS; r++) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    r_w[r][c] <= '0;
                end
            end
        end else if (bus.we_rl) begin
            for (int r = 0; r < NUM_PE_ROWS; r++) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    r_w[r][c] <= r_fifo_dout[WEIGHT_BW*(r*MATRIX_SIZE+c) +: WEIGHT_BW];
                end
            end
        end
    end

    // ------------------------------------------------------- MAC + saturate
    // Operands are sign-extended to AccW before multiplying so the sum is
    // exact; saturation then clamps to the signed WEIGHT_BW range.
    always_comb begin
        w_result = '0;
        for (int r = 0; r < NUM_PE_ROWS; r++) begin
            w_acc[r] = '0;
            for (int c = 0; c < MATRIX_SIZE; c++) begin
                w_acc[r] = w_acc[r] + AccW'(r_w[r][c]) *
                           AccW'($signed(r_sram_q[c*WEIGHT_BW +: WEIGHT_BW]));
            end
            if (w_acc[r] > SatMax) begin
                w_result[r*WEIGHT_BW +: WEIGHT_BW] = SatMax[WEIGHT_BW-1:0];
            end else if (w_acc[r] < SatMin) begin
                w_result[r*WEIGHT_BW +: WEIGHT_BW] = SatMin[WEIGHT_BW-1:0];
            end else begin
                w_result[r*WEIGHT_BW +: WEIGHT_BW] = w_acc[r][WEIGHT_BW-1:0];
            end
        end
    end

    // ---------------------------------------- result capture and flush state
    // start restarts the buffer at entry 0, so a capture in that same cycle
    // always fits.
    assign w_capture = r_act_valid && (bus.start || (r_res_count < ResW'(MATRIX_SIZE)));
    assign w_cap_sel = bus.start ? '0 : r_res_count[SelW-1:0];

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_act_valid <= 1'b0;
            r_res_count <= '0;
            r_flush_idx <= '0;
            r_end       <= 1'b0;
        end else begin
            // Sram_data_out carries the vector one cycle after the address.
            r_act_valid <= bus.valid_address && !bus.addr_ctrl_en;
            if (w_capture) begin
                r_buf[w_cap_sel] <= w_result;
            end
            if (bus.start) begin
                r_res_count <= w_capture ? ResW'(1) : '0;
                r_flush_idx <= '0;
                r_end       <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_res_count <= r_res_count + ResW'(1);
                end
                if (w_flush_wr) begin
                    r_flush_idx <= r_flush_idx + ResW'(1);
                    if (r_flush_idx == r_res_count - ResW'(1)) begin
                        r_end <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.end_          = r_end;
    assign bus.sram_data_out = r_sram_q;
    assign bus.fifo_data_out = r_fifo_dout;
    assign bus.fifo_empty    = w_fifo_empty;
    assign bus.fifo_full     = w_fifo_full;
endmodule

// File: tb/tb_tpu_top.sv
// Self-checking bench for tpu_top: randomized weight tiles and activation
// vectors checked against a behavioural matrix-vector model with saturation.
module tb_tpu_top;
    localparam int unsigned AW    = 10;
    localparam int unsigned WS    = 64;
    localparam int unsigned TileW = 512;
    localparam int unsigned RBase = 512;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [WS-1:0] m_mem [2**AW];
    logic [WS-1:0] vq [$];

    tpu_top_if bus ();

    tpu_top dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [TileW-1:0] got,
                            input logic [TileW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TileW-1:0] rand_tile();
        logic [TileW-1:0] t;
        for (int i = 0; i < TileW / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    function automatic logic [TileW-1:0] fill_tile(input logic [7:0] b);
        logic [TileW-1:0] t;
        for (int i = 0; i < 64; i++) t[i*8 +: 8] = b;
        return t;
    endfunction

    function automatic logic [TileW-1:0] ident_tile();
        logic [TileW-1:0] t;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) t[(r*8+c)*8 +: 8] = (r == c) ? 8'd1 : 8'd0;
        return t;
    endfunction

    // y[r] = clamp(sum_c W[r][c]*a[c], -128, 127)
    function automatic logic [WS-1:0] mv(input logic [TileW-1:0] t, input logic [WS-1:0] a);
        logic [WS-1:0] y;
        for (int r = 0; r < 8; r++) begin
            int s = 0;
            for (int c = 0; c < 8; c++) begin
                int wv = int'($signed(t[(r*8+c)*8 +: 8]));
                int av = int'($signed(a[c*8 +: 8]));
                s += wv * av;
            end
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            y[r*8 +: 8] = 8'(s);
        end
        return y;
    endfunction

    task automatic push(input logic [TileW-1:0] t);
        bus.fifo_data_in = t;
        bus.fifo_write_enable = 1'b1;
        tick();
        bus.fifo_write_enable = 1'b0;
    endtask

    task automatic pop();
        bus.fifo_read_enable = 1'b1;
        tick();
        bus.fifo_read_enable = 1'b0;
    endtask

    task automatic sram_write(input int a, input logic [WS-1:0] d);
        bus.sram_address = AW'(a);
        bus.sram_data_in = d;
        bus.sram_write_enable = 1'b1;
        tick();
        bus.sram_write_enable = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic sram_check(input string tag, input int a);
        bus.sram_address = AW'(a);
        tick();
        check_eq(tag, TileW'(bus.sram_data_out), TileW'(m_mem[a]));
    endtask

    task automatic run_job(input string tag, input logic [TileW-1:0] t);
        int n;
        int expc;
        int cycles;
        n = vq.size();
        expc = (n > 8) ? 8 : n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq({tag, "_end_after_start"}, TileW'(bus.end_), '0);
        push(t);
        pop();
        check_eq({tag, "_tile_pop"}, bus.fifo_data_out, t);
        bus.we_rl = 1'b1;
        tick();
        bus.we_rl = 1'b0;
        for (int i = 0; i < n; i++) sram_write(i, vq[i]);
        for (int i = 0; i < n; i++) begin
            bus.sram_address = AW'(i);
            bus.valid_address = 1'b1;
            tick();
        end
        bus.valid_address = 1'b0;
        tick();
        tick();
        for (int k = 0; k < expc; k++) m_mem[RBase + k] = mv(t, vq[k]);
        bus.addr_ctrl_en = 1'b1;
        cycles = 0;
        if (expc == 0) begin
            repeat (6) tick();
            check_eq({tag, "_end_stays_low"}, TileW'(bus.end_), '0);
        end else begin
            while (!bus.end_ && cycles < 30) begin
                tick();
                cycles++;
            end
            check_eq({tag, "_flush_cycles"}, TileW'(cycles), TileW'(expc));
        end
        bus.addr_ctrl_en = 1'b0;
        for (int k = 0; k < 8; k++) sram_check({tag, "_result"}, RBase + k);
    endtask

    initial begin
        logic [TileW-1:0] tl [5];
        logic [WS-1:0]    w;
        bus.start = 0; bus.sram_write_enable = 0; bus.sram_address = '0;
        bus.sram_data_in = '0; bus.fifo_write_enable = 0; bus.fifo_read_enable = 0;
        bus.fifo_data_in = '0; bus.we_rl = 0; bus.valid_address = 0; bus.addr_ctrl_en = 0;
        rstn = 1'b1;
        tick();
        tick();
        rstn = 1'b0;

        // Reset with two tiles in the FIFO and a nonzero popped tile
        push(rand_tile());
        push(rand_tile());
        push(rand_tile());
        pop();
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        check_eq("rst_empty", TileW'(bus.fifo_empty), TileW'(1));
        check_eq("rst_full", TileW'(bus.fifo_full), '0);
        check_eq("rst_end", TileW'(bus.end_), '0);
        check_eq("rst_fifo_out", bus.fifo_data_out, '0);
        check_eq("rst_sram_out", TileW'(bus.sram_data_out), '0);

        // FIFO ordering, full drop, empty pop
        for (int i = 0; i < 5; i++) begin
            tl[i] = rand_tile();
            push(tl[i]);
            if (i == 3) check_eq("fifo_full4", TileW'(bus.fifo_full), TileW'(1));
        end
        for (int i = 0; i < 4; i++) begin
            pop();
            check_eq("fifo_order", bus.fifo_data_out, tl[i]);
        end
        check_eq("fifo_empty", TileW'(bus.fifo_empty), TileW'(1));
        pop();
        check_eq("fifo_pop_empty", bus.fifo_data_out, tl[3]);

        // SRAM write/read
        sram_write(3, 64'h0807060504030201);
        sram_check("sram_rd3", 3);
        for (int k = 0; k < 8; k++) sram_write(RBase + k, '0);

        // Identity
        vq.delete();
        for (int i = 0; i < 8; i++) vq.push_back(64'h0807060504030201 + 64'(i));
        run_job("ident", ident_tile());

        // Saturation, both directions
        vq.delete();
        vq.push_back(64'h7F7F7F7F7F7F7F7F);
        run_job("sat_pos", fill_tile(8'h7F));
        check_eq("sat_pos_val", TileW'(m_mem[RBase]), TileW'(64'h7F7F7F7F7F7F7F7F));
        run_job("sat_neg", fill_tile(8'h80));
        check_eq("sat_neg_val", TileW'(m_mem[RBase]), TileW'(64'h8080808080808080));

        // Restart with a full buffer already flushed, single new vector
        vq.delete();
        for (int i = 0; i < 8; i++) vq.push_back({$urandom, $urandom});
        run_job("full8", rand_tile());
        vq.delete();
        vq.push_back({$urandom, $urandom});
        run_job("restart1", rand_tile());

        // Random jobs including empty and overflowing buffers
        for (int j = 0; j < 5; j++) begin
            int n;
            n = (j == 0) ? 0 : ((j == 1) ? 10 : int'($urandom_range(1, 10)));
            vq.delete();
            for (int i = 0; i < n; i++) begin
                w = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) w = w & 64'h0F0F0F0F0F0F0F0F;
                vq.push_back(w);
            end
            run_job("rand", rand_tile());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
